// File: rtl/tile_map_renderer.sv
// Tile-map frame renderer: walks the raster left-to-right, top-to-bottom.
// It reads the map once per tile span and looks up tile and sprite pixels.
// It streams each pixel to the display port, with a border colour off-map.
//
// Handshake: pixelWrite is the valid. Once raised, pixelWrite, xAddr, yAddr
// and pixelData stay stable until a cycle with pixelReady=1. That cycle is
// the single accept. pixelWrite drops on the following edge.
module tile_map_renderer #(
    parameter int          SCREEN_W   = 240,
    parameter int          SCREEN_H   = 320,
    parameter int          X_BITS     = 8,
    parameter int          Y_BITS     = 9,
    parameter int          TILE_LOG2  = 3,
    parameter int          MAP_W      = 30,
    parameter int          MAP_H      = 40,
    parameter int          MAP_AW     = 11,
    parameter int          TYPE_BITS  = 2,
    parameter int          MEM_LAT    = 1,
    parameter logic [15:0] TRANSP     = 16'h07E0,
    parameter logic [15:0] BORDER     = 16'h0000,
    parameter int          CONTINUOUS = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic                            sprite_en,
    input  logic [7:0]                      sprite_x,
    input  logic [7:0]                      sprite_y,
    output logic [MAP_AW-1:0]               map_addr,
    input  logic [TYPE_BITS-1:0]            map_type,
    output logic [TYPE_BITS+2*TILE_LOG2-1:0] tile_addr,
    input  logic [15:0]                     tile_data,
    output logic [2*TILE_LOG2-1:0]          sprite_addr,
    input  logic [15:0]                     sprite_data,
    output logic [X_BITS-1:0]               xAddr,
    output logic [Y_BITS-1:0]               yAddr,
    output logic [15:0]                     pixelData,
    output logic                            pixelWrite,
    input  logic                            pixelReady,
    output logic                            busy,
    output logic                            frame_done,
    output logic [2:0]                      state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MAP_REQ  = 3'd1,
        S_MAP_WAIT = 3'd2,
        S_PIX_REQ  = 3'd3,
        S_PIX_WAIT = 3'd4,
        S_WRITE    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [7:0] LAT_W = 8'(MEM_LAT);

    state_t                 state;
    logic [X_BITS-1:0]      x_q;
    logic [Y_BITS-1:0]      y_q;
    logic [TYPE_BITS-1:0]   type_q;
    logic                   border_q;
    logic                   sp_en_q;
    logic [7:0]             sp_x_q;
    logic [7:0]             sp_y_q;
    logic [7:0]             wait_cnt;

    logic [MAP_AW-1:0]      tx_w;
    logic [MAP_AW-1:0]      ty_w;
    logic [MAP_AW-1:0]      map_lin;
    logic                   in_map;
    logic                   x_last;
    logic                   y_last;
    logic [X_BITS-1:0]      nx;
    logic [Y_BITS-1:0]      ny;
    logic [TILE_LOG2-1:0]   x_off;
    logic [TILE_LOG2-1:0]   y_off;
    logic [TILE_LOG2-1:0]   nx_off;
    logic [TILE_LOG2-1:0]   ny_off;
    logic                   sprite_hit;
    logic [15:0]            colour;

    assign state_dbg = state;

    // Tile coordinates, map address, raster advance and pixel colour selection.
    always_comb begin
        tx_w       = MAP_AW'(x_q >> TILE_LOG2);
        ty_w       = MAP_AW'(y_q >> TILE_LOG2);
        map_lin    = ty_w * MAP_AW'(MAP_W) + tx_w;
        in_map     = (32'(x_q >> TILE_LOG2) < MAP_W) && (32'(y_q >> TILE_LOG2) < MAP_H);
        x_last     = (x_q == X_BITS'(SCREEN_W - 1));
        y_last     = (y_q == Y_BITS'(SCREEN_H - 1));
        nx         = x_last ? '0 : x_q + X_BITS'(1);
        ny         = x_last ? y_q + Y_BITS'(1) : y_q;
        x_off      = x_q[TILE_LOG2-1:0];
        y_off      = y_q[TILE_LOG2-1:0];
        nx_off     = nx[TILE_LOG2-1:0];
        ny_off     = ny[TILE_LOG2-1:0];
        sprite_hit = sp_en_q
                     && (32'(x_q >> TILE_LOG2) == 32'(sp_x_q))
                     && (32'(y_q >> TILE_LOG2) == 32'(sp_y_q))
                     && (sprite_data != TRANSP);
        colour     = border_q ? BORDER : (sprite_hit ? sprite_data : tile_data);
    end

    // Frame sequencer. Every output is a register and clears on reset.
    // The pixel lookup address is valid during PIX_REQ, so the lookup data
    // arrives MEM_LAT cycles later, in the last PIX_WAIT cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            type_q      <= '0;
            border_q    <= 1'b0;
            sp_en_q     <= 1'b0;
            sp_x_q      <= '0;
            sp_y_q      <= '0;
            wait_cnt    <= '0;
            map_addr    <= '0;
            tile_addr   <= '0;
            sprite_addr <= '0;
            xAddr       <= '0;
            yAddr       <= '0;
            pixelData   <= '0;
            pixelWrite  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        sp_en_q <= sprite_en;
                        sp_x_q  <= sprite_x;
                        sp_y_q  <= sprite_y;
                        x_q     <= '0;
                        y_q     <= '0;
                        busy    <= 1'b1;
                        state   <= S_MAP_REQ;
                    end
                end
                S_MAP_REQ: begin
                    if (in_map) begin
                        map_addr <= map_lin;
                        border_q <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_MAP_WAIT;
                    end else begin
                        border_q    <= 1'b1;
                        tile_addr   <= {type_q, y_off, x_off};
                        sprite_addr <= {y_off, x_off};
                        state       <= S_PIX_REQ;
                    end
                end
                S_MAP_WAIT: begin
                    // map_addr became visible on entry; the cell arrives MEM_LAT cycles later.
                    if (wait_cnt == LAT_W) begin
                        type_q      <= map_type;
                        tile_addr   <= {map_type, y_off, x_off};
                        sprite_addr <= {y_off, x_off};
                        state       <= S_PIX_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_PIX_REQ: begin
                    wait_cnt <= 8'd1;
                    state    <= S_PIX_WAIT;
                end
                S_PIX_WAIT: begin
                    if (wait_cnt == LAT_W) begin
                        pixelData  <= colour;
                        xAddr      <= x_q;
                        yAddr      <= y_q;
                        pixelWrite <= 1'b1;
                        state      <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WRITE: begin
                    if (pixelReady) begin
                        pixelWrite <= 1'b0;
                        if (x_last && y_last) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            x_q <= nx;
                            y_q <= ny;
                            if (nx_off == '0) begin
                                state <= S_MAP_REQ;
                            end else begin
                                tile_addr   <= {type_q, ny_off, nx_off};
                                sprite_addr <= {ny_off, nx_off};
                                state       <= S_PIX_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (CONTINUOUS != 0) begin
                        sp_en_q <= sprite_en;
                        sp_x_q  <= sprite_x;
                        sp_y_q  <= sprite_y;
                        x_q     <= '0;
                        y_q     <= '0;
                        state   <= S_MAP_REQ;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_map_renderer.sv
// Bench for tile_map_renderer.
// Instance A: 4x4 screen, 2x2 map, 2-pixel tiles, single-frame mode, latency 1.
// Instance B: 6x4 screen, 2x2 map, so column 2 is border; continuous mode, latency 2.
// A reference model derives every pixel and map read from the map contents.
module tb_tile_map_renderer;

    logic clock;
    logic a_rst, b_rst;
    logic a_start, b_start;
    logic a_en, b_en;
    logic [7:0] a_sx, a_sy, b_sx, b_sy;
    logic [1:0] a_maddr, b_maddr;
    logic [1:0] a_mtype, b_mtype, b_mtype_p;
    logic [3:0] a_taddr, b_taddr;
    logic [15:0] a_tdata, b_tdata, b_tdata_p;
    logic [1:0] a_saddr, b_saddr;
    logic [15:0] a_sdata, b_sdata, b_sdata_p;
    logic [2:0] a_x, a_y, b_x, b_y;
    logic [15:0] a_pd, b_pd;
    logic a_pw, b_pw, a_ready, b_ready;
    logic a_busy, b_busy, a_fd, b_fd;
    logic [2:0] a_st, b_st, a_prev_st, b_prev_st;

    logic [1:0]  a_map [4];
    logic [15:0] a_tile [16];
    logic [15:0] a_spr [4];
    logic [1:0]  b_map [4];
    logic [15:0] b_tile [16];
    logic [15:0] b_spr [4];

    logic [21:0] a_exp_q[$];
    logic [21:0] b_exp_q[$];
    logic [1:0]  a_mq[$];
    logic [1:0]  b_mq[$];
    logic [21:0] a_e, b_e;
    logic [1:0]  a_me, b_me;

    int total = 0;
    int bad = 0;
    int a_acc = 0, b_acc = 0;
    int a_done_cnt = 0, b_done_cnt = 0;
    int a_reads = 0, b_reads = 0;
    int a_reads_exp = 0, b_reads_exp = 0;
    bit a_rnd = 0, b_rnd = 0, b_check_busy = 0;
    int acc0, rd0, d0;

    tile_map_renderer #(
        .SCREEN_W(4), .SCREEN_H(4), .X_BITS(3), .Y_BITS(3), .TILE_LOG2(1),
        .MAP_W(2), .MAP_H(2), .MAP_AW(2), .TYPE_BITS(2), .MEM_LAT(1),
        .TRANSP(16'h07E0), .BORDER(16'h0000), .CONTINUOUS(0)
    ) dut_a (
        .clock(clock), .reset(a_rst), .frame_start(a_start), .sprite_en(a_en),
        .sprite_x(a_sx), .sprite_y(a_sy), .map_addr(a_maddr), .map_type(a_mtype),
        .tile_addr(a_taddr), .tile_data(a_tdata), .sprite_addr(a_saddr),
        .sprite_data(a_sdata), .xAddr(a_x), .yAddr(a_y), .pixelData(a_pd),
        .pixelWrite(a_pw), .pixelReady(a_ready), .busy(a_busy),
        .frame_done(a_fd), .state_dbg(a_st)
    );

    tile_map_renderer #(
        .SCREEN_W(6), .SCREEN_H(4), .X_BITS(3), .Y_BITS(3), .TILE_LOG2(1),
        .MAP_W(2), .MAP_H(2), .MAP_AW(2), .TYPE_BITS(2), .MEM_LAT(2),
        .TRANSP(16'h07E0), .BORDER(16'hBEEF), .CONTINUOUS(1)
    ) dut_b (
        .clock(clock), .reset(b_rst), .frame_start(b_start), .sprite_en(b_en),
        .sprite_x(b_sx), .sprite_y(b_sy), .map_addr(b_maddr), .map_type(b_mtype),
        .tile_addr(b_taddr), .tile_data(b_tdata), .sprite_addr(b_saddr),
        .sprite_data(b_sdata), .xAddr(b_x), .yAddr(b_y), .pixelData(b_pd),
        .pixelWrite(b_pw), .pixelReady(b_ready), .busy(b_busy),
        .frame_done(b_fd), .state_dbg(b_st)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memories: one register stage for A, two for B
    always @(posedge clock) begin
        a_mtype   <= a_map[a_maddr];
        a_tdata   <= a_tile[a_taddr];
        a_sdata   <= a_spr[a_saddr];
        b_mtype_p <= b_map[b_maddr];
        b_tdata_p <= b_tile[b_taddr];
        b_sdata_p <= b_spr[b_saddr];
        b_mtype   <= b_mtype_p;
        b_tdata   <= b_tdata_p;
        b_sdata   <= b_sdata_p;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one frame's pixels in raster order and its map reads in order
    task automatic push_frame(input bit sel, input logic en, input logic [7:0] sx, input logic [7:0] sy);
        int w, tx, ty, off, t;
        logic [15:0] bcol, tc, sc, col;
        w = sel ? 6 : 4;
        bcol = sel ? 16'hBEEF : 16'h0000;
        for (int y = 0; y < 4; y++) begin
            ty = y / 2;
            for (int c = 0; c < (w + 1) / 2; c++) begin
                if (c < 2 && ty < 2) begin
                    if (sel) begin b_mq.push_back(2'(ty * 2 + c)); b_reads_exp++; end
                    else begin a_mq.push_back(2'(ty * 2 + c)); a_reads_exp++; end
                end
            end
            for (int x = 0; x < w; x++) begin
                tx = x / 2;
                off = (y % 2) * 2 + (x % 2);
                if (tx >= 2 || ty >= 2) begin
                    col = bcol;
                end else begin
                    t  = int'(sel ? b_map[2'(ty * 2 + tx)] : a_map[2'(ty * 2 + tx)]);
                    tc = sel ? b_tile[4'(t * 4 + off)] : a_tile[4'(t * 4 + off)];
                    sc = sel ? b_spr[2'(off)] : a_spr[2'(off)];
                    col = (en && tx == int'(sx) && ty == int'(sy) && sc != 16'h07E0) ? sc : tc;
                end
                if (sel) b_exp_q.push_back({3'(x), 3'(y), col});
                else a_exp_q.push_back({3'(x), 3'(y), col});
            end
        end
    endtask

    // Scoreboard for instance A: accepted pixels and map reads against the model
    always @(negedge clock) begin
        if (a_pw && a_ready) begin
            a_acc++;
            if (a_exp_q.size() == 0) check("a_extra_pixel", 64'(1), 64'(0));
            else begin
                a_e = a_exp_q.pop_front();
                check("a_pixel", 64'({a_x, a_y, a_pd}), 64'(a_e));
            end
        end
        if (a_fd) a_done_cnt++;
        if (a_st == 3'd2 && a_prev_st != 3'd2) begin
            a_reads++;
            if (a_mq.size() == 0) check("a_extra_map_read", 64'(1), 64'(0));
            else begin
                a_me = a_mq.pop_front();
                check("a_map_addr", 64'(a_maddr), 64'(a_me));
            end
        end
        a_prev_st = a_st;
    end

    // Scoreboard for instance B, plus busy held high across continuous frames
    always @(negedge clock) begin
        if (b_pw && b_ready) begin
            b_acc++;
            if (b_exp_q.size() == 0) check("b_extra_pixel", 64'(1), 64'(0));
            else begin
                b_e = b_exp_q.pop_front();
                check("b_pixel", 64'({b_x, b_y, b_pd}), 64'(b_e));
            end
        end
        if (b_fd) b_done_cnt++;
        if (b_check_busy && b_done_cnt > 0) check("b_busy_continuous", 64'(b_busy), 64'(1));
        if (b_st == 3'd2 && b_prev_st != 3'd2) begin
            b_reads++;
            if (b_mq.size() == 0) check("b_extra_map_read", 64'(1), 64'(0));
            else begin
                b_me = b_mq.pop_front();
                check("b_map_addr", 64'(b_maddr), 64'(b_me));
            end
        end
        b_prev_st = b_st;
    end

    // Driver: one clock step; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
        if (a_rnd) a_ready = ($urandom_range(0, 3) != 0);
        if (b_rnd) b_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_done(input bit sel, input int target);
        int g;
        g = 0;
        while (((sel ? b_done_cnt : a_done_cnt) < target) && g < 3000) begin tick(); g++; end
        check(sel ? "b_done_timeout" : "a_done_timeout", 64'(g >= 3000), 64'(0));
    endtask

    task automatic wait_acc_b(input int target);
        int g;
        g = 0;
        while (b_acc < target && g < 3000) begin tick(); g++; end
        check("b_acc_timeout", 64'(g >= 3000), 64'(0));
    endtask

    task automatic wait_write_a();
        int g;
        g = 0;
        while (!a_pw && g < 200) begin tick(); g++; end
        check("a_write_timeout", 64'(g >= 200), 64'(0));
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    // Wait for frame_done on A and drive frame_start during that same DONE cycle
    task automatic wait_done_a_restart();
        int g;
        bit seen;
        g = 0;
        seen = 0;
        while (!seen && g < 3000) begin
            @(negedge clock);
            g++;
            if (a_fd) begin
                seen = 1;
                a_start = 1'b1;
                @(posedge clock);
                #1;
                a_start = 1'b0;
            end
        end
        check("a_done_restart_timeout", 64'(seen), 64'(1));
    endtask

    task automatic randomize_roms(input bit sel);
        for (int i = 0; i < 4; i++) begin
            if (sel) begin
                b_map[i] = 2'($urandom_range(0, 3));
                b_spr[i] = ($urandom_range(0, 1) != 0) ? 16'h07E0 : 16'($urandom);
            end else begin
                a_map[i] = 2'($urandom_range(0, 3));
                a_spr[i] = ($urandom_range(0, 1) != 0) ? 16'h07E0 : 16'($urandom);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (sel) b_tile[i] = 16'($urandom);
            else a_tile[i] = 16'($urandom);
        end
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        a_en = 1'b0; a_sx = '0; a_sy = '0;
        b_en = 1'b0; b_sx = '0; b_sy = '0;
        a_prev_st = '0; b_prev_st = '0;
        for (int i = 0; i < 4; i++) begin
            a_map[i] = 2'(i);
            a_spr[i] = 16'hFFE0;
            b_map[i] = 2'(i);
            b_spr[i] = 16'hFFE0;
        end
        for (int i = 0; i < 16; i++) begin
            a_tile[i] = 16'(16'h1000 * (i / 4) + (i % 4));
            b_tile[i] = a_tile[i];
        end

        // Reset state, during and after reset
        repeat (3) tick();
        check("a_reset_outputs", 64'({a_pw, a_busy, a_fd, a_x, a_y, a_pd, a_maddr, a_taddr, a_saddr}), 64'(0));
        check("b_reset_outputs", 64'({b_pw, b_busy, b_fd, b_x, b_y, b_pd, b_maddr, b_taddr, b_saddr}), 64'(0));
        a_rst = 1'b0; b_rst = 1'b0;
        repeat (2) tick();
        check("a_idle_outputs", 64'({a_pw, a_busy, a_fd, a_x, a_y}), 64'(0));

        // Reset in the middle of WRITE aborts the frame
        push_frame(0, 1'b0, 8'd0, 8'd0);
        a_ready = 1'b0;
        pulse_start_a();
        wait_write_a();
        repeat (2) tick();
        #1 a_rst = 1'b1;
        #1 check("a_abort_same_cycle", 64'({a_pw, a_busy, a_x}), 64'(0));
        a_exp_q.delete();
        a_mq.delete();
        tick();
        a_rst = 1'b0;
        a_reads = 0;
        a_reads_exp = 0;
        repeat (5) tick();
        check("a_no_done_after_abort", 64'(a_done_cnt), 64'(0));

        // Directed frame with stall: ready low 5 cycles, then free-running
        push_frame(0, 1'b0, 8'd0, 8'd0);
        acc0 = a_acc; rd0 = a_reads; d0 = a_done_cnt;
        pulse_start_a();
        wait_write_a();
        for (int i = 0; i < 5; i++) begin
            a_start = (i == 2);
            tick();
            check("a_hold_stable", 64'({a_pw, a_x, a_y, a_pd}), 64'({1'b1, a_exp_q[0]}));
        end
        a_start = 1'b0;
        a_ready = 1'b1;
        wait_done_a_restart();
        repeat (10) tick();
        check("a_frame_done_once", 64'(a_done_cnt - d0), 64'(1));
        check("a_write_count", 64'(a_acc - acc0), 64'(16));
        check("a_map_reads", 64'(a_reads - rd0), 64'(a_reads_exp));
        check("a_queue_empty", 64'(a_exp_q.size() + a_mq.size()), 64'(0));
        check("a_idle_after_done", 64'(a_busy), 64'(0));

        // Sprite at tile (1,0), transparent at offset 0
        a_spr[0] = 16'h07E0;
        a_en = 1'b1; a_sx = 8'd1; a_sy = 8'd0;
        push_frame(0, 1'b1, 8'd1, 8'd0);
        d0 = a_done_cnt;
        pulse_start_a();
        wait_done(0, d0 + 1);
        repeat (3) tick();
        check("a_sprite_queue_empty", 64'(a_exp_q.size()), 64'(0));

        // Random maps, ROMs, sprite placement and ready back-pressure
        for (int f = 0; f < 3; f++) begin
            randomize_roms(0);
            a_en = 1'($urandom_range(0, 1));
            a_sx = 8'($urandom_range(0, 2));
            a_sy = 8'($urandom_range(0, 2));
            push_frame(0, a_en, a_sx, a_sy);
            d0 = a_done_cnt;
            a_rnd = 1;
            pulse_start_a();
            wait_done(0, d0 + 1);
            a_rnd = 0;
            a_ready = 1'b1;
            repeat (3) tick();
            check("a_rand_queue_empty", 64'(a_exp_q.size() + a_mq.size()), 64'(0));
        end

        // Continuous mode with border columns; sprite_x changes mid-frame
        randomize_roms(1);
        b_en = 1'b1; b_sx = 8'd0; b_sy = 8'd0;
        push_frame(1, 1'b1, 8'd0, 8'd0);
        b_check_busy = 1;
        b_rnd = 1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_acc_b(10);
        b_sx = 8'd1;
        push_frame(1, 1'b1, 8'd1, 8'd0);
        wait_acc_b(34);
        b_sx = 8'd2;
        push_frame(1, 1'b1, 8'd2, 8'd0);
        wait_done(1, 3);
        b_check_busy = 0;
        b_rst = 1'b1;
        #1 check("b_reset_clears_busy", 64'({b_busy, b_pw}), 64'(0));
        tick();
        check("b_done_count", 64'(b_done_cnt), 64'(3));
        check("b_write_count", 64'(b_acc), 64'(72));
        check("b_map_reads", 64'(b_reads), 64'(b_reads_exp));
        check("b_queue_empty", 64'(b_exp_q.size() + b_mq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
